// File: rtl/neopixel.sv
// ---------------------------------------------------------------------------
// neopixel
//   WS2812 / NeoPixel strip driver with an internal frame buffer holding
//   NUM_LEDS 24-bit pixel words.  Pixel writes come in via the color_clock
//   strobe, which may be asynchronous to clk.  The strip is refreshed
//   continuously and autonomously over the single-wire leds output.
//
// Ports
//   clk          in   1   system clock, all logic on posedge (~25 MHz)
//   rst          in   1   asynchronous active-high reset
//   color        in   24  pixel word {G,R,B}, transmitted MSB first
//   address      in   16  pixel index for the write, 0..NUM_LEDS-1
//   color_clock  in   1   write strobe; a rising edge writes color to
//                         buffer[address]
//   leds         out  1   serial NeoPixel data line (registered)
//
// Timing
//   Every bit occupies exactly T_BIT cycles on leds: T0H or T1H cycles high,
//   then low for the rest of the period.  The last bit of a pixel stays in
//   BITS for only T_BIT-1 cycles.  The one-cycle LOAD that fetches the next
//   word supplies the missing cycle, so the bit pitch never changes.
//
//   After the last pixel the line is held low for the latch gap.  Measured
//   from the end of the last bit period to the next frame's first rising
//   edge, this gap is exactly T_RESET cycles.
//
//   leds is registered.  It therefore trails the FSM by one cycle, which
//   shifts every edge equally and leaves all widths and periods intact.
// ---------------------------------------------------------------------------
module neopixel #(
    parameter int NUM_LEDS = 150,
    parameter int T_BIT    = 32,
    parameter int T0H      = 10,
    parameter int T1H      = 20,
    parameter int T_RESET  = 1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] color,
    input  logic [15:0] address,
    input  logic        color_clock,
    output logic        leds
);

    // ------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------
    localparam int IW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int CMAX = (T_RESET > T_BIT) ? T_RESET : T_BIT;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] RESET_LAST     = CW'(T_RESET - 1);
    localparam logic [CW-1:0] BIT_LAST       = CW'(T_BIT - 1);
    // The last bit of a pixel ends one cycle early; LOAD or LATCH completes it.
    localparam logic [CW-1:0] BIT_LAST_SHORT = CW'(T_BIT - 2);
    localparam logic [CW-1:0] HIGH_ONE       = CW'(T1H);
    localparam logic [CW-1:0] HIGH_ZERO      = CW'(T0H);
    localparam logic [IW-1:0] IDX_LAST       = IW'(NUM_LEDS - 1);
    localparam logic [16:0]   NUM_LEDS_W     = 17'(NUM_LEDS);
    localparam logic [4:0]    BIT_MSB        = 5'd23;

    typedef enum logic [1:0] {
        ST_LATCH = 2'd0,
        ST_LOAD  = 2'd1,
        ST_BITS  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Strobe synchronizer and rising-edge detect
    // ------------------------------------------------------------------
    logic [2:0] sync_q;
    logic [2:0] sync_d;
    logic       wr_edge;
    logic       addr_ok;
    logic       wr_en;

    // Shift the raw strobe into a 2-FF synchronizer plus one history stage.
    always_comb begin
        sync_d = {sync_q[1:0], color_clock};
    end

    // Synchronizer register, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    // A write happens only on a 0->1 transition of the synchronized strobe
    // and only when the address is in range.
    always_comb begin
        wr_edge = sync_q[1] & ~sync_q[2];
        addr_ok = ({1'b0, address} < NUM_LEDS_W);
        wr_en   = wr_edge & addr_ok;
    end

    // ------------------------------------------------------------------
    // Frame buffer (RAM, not touched by reset)
    // ------------------------------------------------------------------
    logic [23:0] mem [NUM_LEDS];
    logic [23:0] load_word;

    // Pixel write port.  Reads below see the pre-write value in the same
    // cycle, which gives read-before-write when LOAD and a write collide.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[address[IW-1:0]] <= color;
        end
    end

    // ------------------------------------------------------------------
    // Output FSM
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [4:0]    bit_q, bit_d;
    logic [23:0]   shift_q, shift_d;
    logic          leds_q, leds_d;

    // Read port of the frame buffer, addressed by the pixel being loaded.
    always_comb begin
        load_word = mem[idx_q];
    end

    // Next-state and output logic for the serializer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        leds_d  = 1'b0;

        case (state_q)
            ST_LATCH: begin
                idx_d = '0;
                if (cnt_q == RESET_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_LOAD: begin
                shift_d = load_word;
                bit_d   = BIT_MSB;
                cnt_d   = '0;
                state_d = ST_BITS;
            end

            ST_BITS: begin
                leds_d = (cnt_q < (shift_q[23] ? HIGH_ONE : HIGH_ZERO));
                if (bit_q != 5'd0) begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        bit_d   = bit_q - 5'd1;
                        shift_d = {shift_q[22:0], 1'b0};
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    if (cnt_q == BIT_LAST_SHORT) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_LATCH;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = ST_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_LATCH;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // FSM state, counters, shift register and the registered line driver.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LATCH;
            cnt_q   <= '0;
            idx_q   <= '0;
            bit_q   <= 5'd0;
            shift_q <= 24'd0;
            leds_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            leds_q  <= leds_d;
        end
    end

    assign leds = leds_q;

endmodule

// File: tb/tb_neopixel.sv
module tb_neopixel;

    localparam int NUM_LEDS = 3;
    localparam int T_BIT    = 32;
    localparam int T0H      = 10;
    localparam int T1H      = 20;
    localparam int T_RESET  = 1500;
    localparam int NBITS    = NUM_LEDS * 24;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] color;
    logic [15:0] address;
    logic        color_clock;
    logic        leds;

    int total = 0;
    int bad   = 0;

    // reference buffer: what each pixel should hold
    logic [23:0] model [NUM_LEDS];

    // results of the most recent decoded frame
    logic [23:0] got_px [NUM_LEDS];
    int          cap_high [NBITS];
    int          cap_bad_width;
    int          cap_bad_period;
    int          cap_gap;
    int          cap_total;
    bit          cap_timeout;

    neopixel #(
        .NUM_LEDS(NUM_LEDS), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_RESET(T_RESET)
    ) dut (
        .clk(clk), .rst(rst), .color(color), .address(address),
        .color_clock(color_clock), .leds(leds)
    );

    always #5 clk = ~clk;

    // Strobe a write; the model follows the rule that only in-range addresses land.
    task automatic write_px(input logic [15:0] a, input logic [23:0] c);
        address = a;
        color   = c;
        repeat (4) @(negedge clk);
        color_clock = 1'b1;
        repeat (5) @(negedge clk);
        color_clock = 1'b0;
        repeat (4) @(negedge clk);
        if (a < NUM_LEDS) model[a] = c;
    endtask

    // Decode one frame from leds.  If not aligned, first wait for a latch gap
    // and the following rising edge.  Returns with leds high at the start of
    // the next frame.
    task automatic capture(input bit aligned);
        int h, l, lim;
        bit b;
        cap_bad_width  = 0;
        cap_bad_period = 0;
        cap_gap        = -1;
        cap_total      = 0;
        cap_timeout    = 1'b0;
        if (!aligned) begin
            l = 0;
            lim = 0;
            while (l < 2 * T_BIT && lim < 20000) begin
                @(negedge clk);
                lim++;
                if (leds) l = 0; else l++;
            end
            while (!leds && lim < 20000) begin
                @(negedge clk);
                lim++;
            end
            if (lim >= 20000) cap_timeout = 1'b1;
        end
        for (int i = 0; i < NBITS; i++) begin
            if (!cap_timeout) begin
                h = 0;
                while (leds && h < T_BIT + 2) begin
                    h++;
                    @(negedge clk);
                end
                l = 0;
                while (!leds && l < T_BIT + T_RESET + 10) begin
                    l++;
                    @(negedge clk);
                end
                if (leds !== 1'b1) cap_timeout = 1'b1;
                cap_high[i] = h;
                b = 1'b0;
                if (h == T1H) b = 1'b1;
                else if (h != T0H) cap_bad_width++;
                got_px[i / 24][23 - (i % 24)] = b;
                cap_total += h + l;
                if (i < NBITS - 1) begin
                    if (h + l != T_BIT) cap_bad_period++;
                end else begin
                    cap_gap = l - (T_BIT - h);
                end
            end
        end
    endtask

    task automatic test_reset();
        int l;
        rst = 1'b1;
        color_clock = 1'b0;
        color = 24'd0;
        address = 16'd0;
        repeat (3) @(negedge clk);
        total++;
        if (leds !== 1'b0) begin
            bad++;
            $display("FAIL reset_state leds=%b want 0", leds);
        end
        rst = 1'b0;
        l = 0;
        while (!leds && l < T_RESET + 200) begin
            @(negedge clk);
            l++;
        end
        total++;
        if (l < T_RESET || leds !== 1'b1) begin
            bad++;
            $display("FAIL reset_gap low=%0d want >=%0d then high", l, T_RESET);
        end
        // leds is high at the start of a bit; hit reset mid high-phase
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (leds !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort leds=%b want 0", leds);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        l = 0;
        while (!leds && l < T_RESET + 200) begin
            @(negedge clk);
            l++;
        end
        total++;
        if (l < T_RESET || leds !== 1'b1) begin
            bad++;
            $display("FAIL reset_regap low=%0d want >=%0d then high", l, T_RESET);
        end
    endtask

    task automatic test_single_pixel();
        int wrong;
        write_px(16'd0, 24'hFF0000);
        write_px(16'd1, 24'h000000);
        write_px(16'd2, 24'h000000);
        capture(1'b0);
        wrong = 0;
        for (int i = 0; i < NBITS; i++)
            if (cap_high[i] != ((i < 8) ? T1H : T0H)) wrong++;
        total++;
        if (cap_timeout || wrong != 0) begin
            bad++;
            $display("FAIL ff0000_widths wrong_bits=%0d timeout=%0d want 0", wrong, cap_timeout);
        end
        total++;
        if (cap_bad_period != 0) begin
            bad++;
            $display("FAIL ff0000_period bad_periods=%0d want 0", cap_bad_period);
        end
    endtask

    task automatic test_pixel1();
        write_px(16'd1, 24'hA55A01);
        capture(1'b0);
        total++;
        if (cap_timeout || got_px[1] !== 24'hA55A01) begin
            bad++;
            $display("FAIL pixel1 got=%h want=a55a01 timeout=%0d", got_px[1], cap_timeout);
        end
        for (int p = 0; p < NUM_LEDS; p++) begin
            total++;
            if (got_px[p] !== model[p]) begin
                bad++;
                $display("FAIL pixel1_frame px%0d got=%h want=%h", p, got_px[p], model[p]);
            end
        end
    endtask

    task automatic test_ignored_writes();
        write_px(16'd150, 24'hFFFFFF);
        write_px(16'd3, 24'hFFFFFF);
        // rising edge with a bad address, then a valid address while held
        // high and on the falling edge: neither may write
        address = 16'd200;
        color = 24'hFFFFFF;
        repeat (4) @(negedge clk);
        color_clock = 1'b1;
        repeat (6) @(negedge clk);
        address = 16'd1;
        color = 24'h123456;
        repeat (10) @(negedge clk);
        color_clock = 1'b0;
        repeat (10) @(negedge clk);
        capture(1'b0);
        for (int p = 0; p < NUM_LEDS; p++) begin
            total++;
            if (cap_timeout || got_px[p] !== model[p]) begin
                bad++;
                $display("FAIL ignored px%0d got=%h want=%h", p, got_px[p], model[p]);
            end
        end
    endtask

    task automatic test_write_during_send();
        logic [23:0] old0;
        logic [23:0] new0;
        capture(1'b0);
        old0 = model[0];
        new0 = ~old0;
        fork
            capture(1'b1);
            begin
                repeat (2 * 24 * T_BIT + 100) @(negedge clk);
                write_px(16'd0, new0);
            end
        join
        total++;
        if (cap_timeout || got_px[0] !== old0) begin
            bad++;
            $display("FAIL late_write_this got=%h want=%h", got_px[0], old0);
        end
        capture(1'b1);
        total++;
        if (cap_timeout || got_px[0] !== new0) begin
            bad++;
            $display("FAIL late_write_next got=%h want=%h", got_px[0], new0);
        end
    endtask

    task automatic test_frame_length();
        for (int f = 0; f < 2; f++) begin
            capture(1'b1);
            total++;
            if (cap_timeout || cap_total != NBITS * T_BIT + T_RESET) begin
                bad++;
                $display("FAIL frame_len got=%0d want=%0d", cap_total, NBITS * T_BIT + T_RESET);
            end
            total++;
            if (cap_gap != T_RESET || cap_bad_period != 0 || cap_bad_width != 0) begin
                bad++;
                $display("FAIL frame_gap gap=%0d want=%0d periods=%0d widths=%0d",
                         cap_gap, T_RESET, cap_bad_period, cap_bad_width);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < NUM_LEDS; p++)
                write_px(16'(p), 24'($urandom));
            write_px(16'($urandom_range(65535, NUM_LEDS)), 24'($urandom));
            capture(1'b0);
            for (int p = 0; p < NUM_LEDS; p++) begin
                total++;
                if (cap_timeout || got_px[p] !== model[p]) begin
                    bad++;
                    $display("FAIL random r%0d px%0d got=%h want=%h", r, p, got_px[p], model[p]);
                end
            end
            total++;
            if (cap_bad_width != 0 || cap_bad_period != 0 || cap_gap != T_RESET) begin
                bad++;
                $display("FAIL random_timing widths=%0d periods=%0d gap=%0d want 0/0/%0d",
                         cap_bad_width, cap_bad_period, cap_gap, T_RESET);
            end
        end
    endtask

    initial begin
        for (int p = 0; p < NUM_LEDS; p++) model[p] = 24'd0;
        test_reset();
        test_single_pixel();
        test_pixel1();
        test_ignored_writes();
        test_write_during_send();
        test_frame_length();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
